// File: rtl/div_clk_mode_detect_if.sv
// rtl/div_clk_mode_detect_if.sv - divided-clock input and recovered mode/lock status bundle
interface div_clk_mode_detect_if;
  logic       IN;
  logic [1:0] mode;
  logic       locked;
  logic       err;

  modport master (
    output IN,
    input  mode,
    input  locked,
    input  err
  );

  modport slave (
    input  IN,
    output mode,
    output locked,
    output err
  );
endinterface

// File: rtl/div_clk_mode_detect.sv
// rtl/div_clk_mode_detect.sv - recovers 4-mode divider setting from measured half-periods
module div_clk_mode_detect #(
  parameter int HALF0   = 2499,
  parameter int HALF1   = 1249,
  parameter int HALF2   = 624,
  parameter int HALF3   = 311,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  div_clk_mode_detect_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT - 1);

  logic          s1, s2, s3;
  logic          edge_det;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   meas;
  logic          have_q, have_d;
  state_t        state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic [1:0]    mode_q, mode_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          cls_hit;
  logic [1:0]    cls_k;

  // s1/s2 resolve metastability; s3 only serves the edge comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 ^ s3;
  assign meas     = {1'b0, cnt_q} + (CW+1)'(1);

  function automatic logic in_win(input logic [CW:0] m, input int half);
    int d;
    d = int'(m) - half;
    return (d >= -TOL) && (d <= TOL);
  endfunction

  // Priority order gives the lowest mode index when windows overlap.
  always_comb begin
    cls_hit = 1'b1;
    cls_k   = 2'd0;
    if (in_win(meas, HALF0)) begin
      cls_k = 2'd0;
    end else if (in_win(meas, HALF1)) begin
      cls_k = 2'd1;
    end else if (in_win(meas, HALF2)) begin
      cls_k = 2'd2;
    end else if (in_win(meas, HALF3)) begin
      cls_k = 2'd3;
    end else begin
      cls_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      cnt_q    <= '0;
      have_q   <= 1'b0;
      cand_q   <= 2'd0;
      mode_q   <= 2'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      have_q   <= have_d;
      cand_q   <= cand_d;
      mode_q   <= mode_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    have_d   = have_q;
    cand_d   = cand_q;
    mode_d   = mode_q;
    locked_d = locked_q;
    err_d    = 1'b0;

    if (edge_det) begin
      cnt_d = '0;
      if (!have_q) begin
        // First edge only opens a measurement window; nothing to classify yet.
        have_d = 1'b1;
      end else begin
        case (state_q)
          SEARCH: begin
            if (cls_hit) begin
              state_d = CONFIRM;
              cand_d  = cls_k;
            end
          end
          CONFIRM: begin
            if (!cls_hit) begin
              state_d = SEARCH;
            end else if (cls_k == cand_q) begin
              state_d  = LOCKED;
              mode_d   = cand_q;
              locked_d = 1'b1;
            end else begin
              cand_d = cls_k;
            end
          end
          LOCKED: begin
            if (!cls_hit) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              err_d    = 1'b1;
            end else if (cls_k != mode_q) begin
              state_d  = CONFIRM;
              cand_d   = cls_k;
              locked_d = 1'b0;
              err_d    = 1'b1;
            end
          end
          default: begin
            state_d  = SEARCH;
            locked_d = 1'b0;
          end
        endcase
      end
    end else begin
      if (cnt_q < TMO) begin
        cnt_d = cnt_q + CW'(1);
      end
      // Fires once on the way up; the counter then parks at TIMEOUT.
      if (cnt_q == TMO_M1) begin
        state_d  = SEARCH;
        have_d   = 1'b0;
        locked_d = 1'b0;
        err_d    = (state_q == LOCKED);
      end
    end
  end

  assign bus.mode   = mode_q;
  assign bus.locked = locked_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_div_clk_mode_detect.sv
// tb/tb_div_clk_mode_detect.sv - directed bench for div_clk_mode_detect
module tb_div_clk_mode_detect;
  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   err_cnt;
  int   snap;

  div_clk_mode_detect_if bus ();

  div_clk_mode_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.err === 1'b1) err_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tog();
    bus.IN = ~bus.IN;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    bus.IN = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  // Three toggles h apart, then wait until the third edge has been processed.
  task automatic lock_run(input int h);
    tog(); cyc(h);
    tog(); cyc(h);
    tog(); cyc(3);
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    err_cnt = 0;
    bus.IN  = 1'b0;
    rst     = 1'b1;
    cyc(2);
    check("reset_mode", 32'(bus.mode), 32'd0);
    check("reset_locked", 32'(bus.locked), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst = 1'b0;

    // Mode 0 from reset, with exact lock latency.
    snap = err_cnt;
    tog(); cyc(2499);
    tog(); cyc(2499);
    tog(); cyc(2);
    check("m0_locked_early", 32'(bus.locked), 32'd0);
    cyc(1);
    check("m0_locked", 32'(bus.locked), 32'd1);
    check("m0_mode", 32'(bus.mode), 32'd0);
    check("m0_no_err", 32'(err_cnt), 32'(snap));

    do_reset();
    lock_run(311);
    check("m3_locked", 32'(bus.locked), 32'd1);
    check("m3_mode", 32'(bus.mode), 32'd3);

    do_reset();
    lock_run(1249);
    check("m1_locked", 32'(bus.locked), 32'd1);
    check("m1_mode", 32'(bus.mode), 32'd1);

    do_reset();
    lock_run(624);
    check("m2_locked", 32'(bus.locked), 32'd1);
    check("m2_mode", 32'(bus.mode), 32'd2);

    // Mode change 1 -> 2 while locked.
    do_reset();
    tog(); cyc(1249);
    tog(); cyc(1249);
    tog(); cyc(3);
    check("sw_locked1", 32'(bus.locked), 32'd1);
    check("sw_mode1", 32'(bus.mode), 32'd1);
    cyc(621);
    tog(); cyc(2);
    check("sw_err_pre", 32'(bus.err), 32'd0);
    check("sw_locked_pre", 32'(bus.locked), 32'd1);
    cyc(1);
    check("sw_err", 32'(bus.err), 32'd1);
    check("sw_unlocked", 32'(bus.locked), 32'd0);
    cyc(1);
    check("sw_err_clear", 32'(bus.err), 32'd0);
    cyc(620);
    tog(); cyc(2);
    check("sw_relock_early", 32'(bus.locked), 32'd0);
    cyc(1);
    check("sw_relock", 32'(bus.locked), 32'd1);
    check("sw_mode2", 32'(bus.mode), 32'd2);

    // Tolerance edges.
    do_reset();
    lock_run(2503);
    check("tol_hi_in_locked", 32'(bus.locked), 32'd1);
    check("tol_hi_in_mode", 32'(bus.mode), 32'd0);
    do_reset();
    lock_run(2504);
    check("tol_hi_out_locked", 32'(bus.locked), 32'd0);
    do_reset();
    lock_run(307);
    check("tol_lo_in_locked", 32'(bus.locked), 32'd1);
    check("tol_lo_in_mode", 32'(bus.mode), 32'd3);
    do_reset();
    lock_run(316);
    check("tol_out316_locked", 32'(bus.locked), 32'd0);

    // Timeout while locked: 4096 clk after the last processed edge.
    do_reset();
    tog(); cyc(311);
    tog(); cyc(311);
    tog(); cyc(3);
    check("to_locked", 32'(bus.locked), 32'd1);
    cyc(4095);
    check("to_locked_pre", 32'(bus.locked), 32'd1);
    check("to_err_pre", 32'(bus.err), 32'd0);
    cyc(1);
    check("to_err", 32'(bus.err), 32'd1);
    check("to_unlocked", 32'(bus.locked), 32'd0);
    cyc(1);
    snap = err_cnt;
    check("to_err_clear", 32'(bus.err), 32'd0);
    cyc(300);
    check("to_no_more_err", 32'(err_cnt), 32'(snap));
    check("to_mode_held", 32'(bus.mode), 32'd3);

    // Reset while locked, then relock from fresh edges.
    do_reset();
    lock_run(311);
    check("rst_pre_locked", 32'(bus.locked), 32'd1);
    bus.IN = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    tog(); cyc(311);
    tog(); cyc(311);
    tog(); cyc(2);
    check("rst_relock_early", 32'(bus.locked), 32'd0);
    cyc(1);
    check("rst_relock", 32'(bus.locked), 32'd1);
    check("rst_relock_mode", 32'(bus.mode), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
